// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Serial receiver for the host link. Oversamples an idle-high asynchronous
// line, recovers start / data (LSB first) / optional even parity / stop
// frames and hands each byte to the command/matrix loader.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-low reset
//   sys_reset  - synchronous, active-high soft reset (same effect as reset)
//   enable     - 1 = frames may start; a frame in progress always completes
//   rx         - asynchronous serial line, idle high
//   rx_data    - last received data word, held between frames
//   rx_valid   - one-cycle pulse, rx_data updated
//   parity_err - qualifies rx_valid: received parity was not even
//   frame_err  - one-cycle pulse, stop bit sampled low (no rx_valid)
//   busy       - high in any state other than IDLE
module uart_rx_deframer #(
   parameter int BAUD_DIV  = 434,
   parameter int DATA_BITS = 8,
   parameter int PARITY_EN = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sys_reset,
   input  logic                 enable,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int BW = $clog2(BAUD_DIV);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] HALF_PT  = BW'(BAUD_DIV / 2 - 1);
   localparam logic [BW-1:0] FULL_PT  = BW'(BAUD_DIV - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                 r_state, w_state;
   logic                   r_sync1, r_sync2;
   logic [BW-1:0]          r_bcnt, w_bcnt;
   logic [IW-1:0]          r_bidx, w_bidx;
   logic [DATA_BITS-1:0]   r_shift, w_shift;
   logic                   r_parbit, w_parbit;
   logic [DATA_BITS-1:0]   r_rx_data, w_rx_data;
   logic                   r_rx_valid, w_rx_valid;
   logic                   r_parity_err, w_parity_err;
   logic                   r_frame_err, w_frame_err;
   logic                   w_half, w_full, w_perr;

   assign w_half = (r_bcnt == HALF_PT);
   assign w_full = (r_bcnt == FULL_PT);
   // Even parity: data XOR parity bit must be 0.
   assign w_perr = (PARITY_EN != 0) ? ((^r_shift) ^ r_parbit) : 1'b0;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= S_IDLE;
      else if (sys_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state;
   end

   // Next state, counters and output strobes
   always_comb begin
      w_state      = r_state;
      w_bcnt       = r_bcnt;
      w_bidx       = r_bidx;
      w_shift      = r_shift;
      w_parbit     = r_parbit;
      w_rx_data    = r_rx_data;
      w_rx_valid   = 1'b0;
      w_parity_err = 1'b0;
      w_frame_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_bcnt = '0;
            if (enable && !r_sync2)
               w_state = S_START;
         end
         S_START: begin
            // Half-bit check; clearing bcnt here puts later samples mid-bit.
            if (w_half) begin
               w_bcnt  = '0;
               w_bidx  = '0;
               w_state = r_sync2 ? S_IDLE : S_DATA;
            end else begin
               w_bcnt = r_bcnt + BW'(1);
            end
         end
         S_DATA: begin
            if (w_full) begin
               w_bcnt = '0;
               for (int i = 0; i < DATA_BITS; i++)
                  if (r_bidx == IW'(i))
                     w_shift[i] = r_sync2;
               w_bidx = r_bidx + IW'(1);
               if (r_bidx == LAST_BIT)
                  w_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
               w_bcnt = r_bcnt + BW'(1);
            end
         end
         S_PARITY: begin
            if (w_full) begin
               w_bcnt   = '0;
               w_parbit = r_sync2;
               w_state  = S_STOP;
            end else begin
               w_bcnt = r_bcnt + BW'(1);
            end
         end
         S_STOP: begin
            // Sampling mid-stop lets the next start edge arrive half a bit early.
            if (w_full) begin
               w_bcnt = '0;
               if (r_sync2) begin
                  w_rx_data    = r_shift;
                  w_rx_valid   = 1'b1;
                  w_parity_err = w_perr;
                  w_state      = S_IDLE;
               end else begin
                  w_frame_err = 1'b1;
                  w_state     = S_BREAK;
               end
            end else begin
               w_bcnt = r_bcnt + BW'(1);
            end
         end
         S_BREAK: begin
            // A held-low line reports a single frame_err, then waits for idle.
            w_bcnt = '0;
            if (r_sync2)
               w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end

   // Synchronizer, counters and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1      <= 1'b1;
         r_sync2      <= 1'b1;
         r_bcnt       <= '0;
         r_bidx       <= '0;
         r_shift      <= '0;
         r_parbit     <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else if (sys_reset) begin
         r_sync1      <= 1'b1;
         r_sync2      <= 1'b1;
         r_bcnt       <= '0;
         r_bidx       <= '0;
         r_shift      <= '0;
         r_parbit     <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_sync1      <= rx;
         r_sync2      <= r_sync1;
         r_bcnt       <= w_bcnt;
         r_bidx       <= w_bidx;
         r_shift      <= w_shift;
         r_parbit     <= w_parbit;
         r_rx_data    <= w_rx_data;
         r_rx_valid   <= w_rx_valid;
         r_parity_err <= w_parity_err;
         r_frame_err  <= w_frame_err;
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer
// Bench for uart_rx_deframer: instance A with even parity, instance B without
// parity, both BAUD_DIV=8 and 8 data bits. A monitor records every strobe as
// an event; each test compares the recorded events against what the frame
// rules predict for the bits that were put on the line.
module tb_uart_rx_deframer;

   localparam int BAUD = 8;

   typedef struct packed {
      logic       fe;
      logic       pe;
      logic [7:0] d;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset, sys_reset;
   logic       en_a, rx_a, en_b, rx_b;
   logic [7:0] data_a, data_b;
   logic       val_a, pe_a, fe_a, busy_a;
   logic       val_b, pe_b, fe_b, busy_b;

   int   checks = 0;
   int   errors = 0;
   ev_t  obs_a[$];
   ev_t  obs_b[$];
   int   viol_a = 0, viol_b = 0;
   logic pv_a = 1'b0, pf_a = 1'b0, pv_b = 1'b0, pf_b = 1'b0;
   logic [7:0] last_a = 8'h00;

   always #5 clk = ~clk;

   uart_rx_deframer #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(1)) dut_a (
      .clk(clk), .reset(reset), .sys_reset(sys_reset), .enable(en_a), .rx(rx_a),
      .rx_data(data_a), .rx_valid(val_a), .parity_err(pe_a), .frame_err(fe_a),
      .busy(busy_a));

   uart_rx_deframer #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(0)) dut_b (
      .clk(clk), .reset(reset), .sys_reset(sys_reset), .enable(en_b), .rx(rx_b),
      .rx_data(data_b), .rx_valid(val_b), .parity_err(pe_b), .frame_err(fe_b),
      .busy(busy_b));

   // Strobe monitor: records events, counts strobe-rule violations.
   always @(negedge clk) begin
      if (val_a) obs_a.push_back(ev_t'({1'b0, pe_a, data_a}));
      if (fe_a)  obs_a.push_back(ev_t'({1'b1, pe_a, data_a}));
      if ((val_a && fe_a) || (pe_a && !val_a) || (val_a && pv_a) || (fe_a && pf_a))
         viol_a++;
      pv_a = val_a;
      pf_a = fe_a;
      if (val_b) obs_b.push_back(ev_t'({1'b0, pe_b, data_b}));
      if (fe_b)  obs_b.push_back(ev_t'({1'b1, pe_b, data_b}));
      if ((val_b && fe_b) || (pe_b && !val_b) || (val_b && pv_b) || (fe_b && pf_b))
         viol_b++;
      pv_b = val_b;
      pf_b = fe_b;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic send_bit(input int sel, input logic b);
      if (sel == 0) rx_a = b; else rx_b = b;
      repeat (BAUD) @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                             input logic s, input logic with_par);
      send_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
      if (with_par) send_bit(sel, p);
      send_bit(sel, s);
   endtask

   task automatic idle_bits(input int sel, input int n);
      if (sel == 0) rx_a = 1'b1; else rx_b = 1'b1;
      repeat (n * BAUD) @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({data_a, val_a, pe_a, fe_a, busy_a} !== 12'h000) begin
         errors++;
         $display("FAIL reset_a: got %h want 000", {data_a, val_a, pe_a, fe_a, busy_a});
      end
      checks++;
      if ({data_b, val_b, pe_b, fe_b, busy_b} !== 12'h000) begin
         errors++;
         $display("FAIL reset_b: got %h want 000", {data_b, val_b, pe_b, fe_b, busy_b});
      end
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({busy_a, busy_b, val_a, fe_a} !== 4'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got %b want 0000", {busy_a, busy_b, val_a, fe_a});
      end
   endtask

   task automatic test_basic;
      int   blow;
      ev_t  got;
      blow = 0;
      fork
         send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
         begin
            repeat (4) @(negedge clk);
            for (int k = 4; k <= 84; k++) begin
               if (!busy_a) blow++;
               @(negedge clk);
            end
         end
      join
      checks++;
      if (blow !== 0) begin
         errors++;
         $display("FAIL basic_busy: busy low in %0d cycles want 0", blow);
      end
      checks++;
      if (obs_a.size() !== 1) begin
         errors++;
         $display("FAIL basic_count: got %0d events want 1", obs_a.size());
      end
      got = (obs_a.size() > 0) ? obs_a.pop_front() : 'x;
      checks++;
      if (got !== ev_t'({1'b0, 1'b0, 8'hA5})) begin
         errors++;
         $display("FAIL basic_event: got %h want %h", got, ev_t'({1'b0, 1'b0, 8'hA5}));
      end
      obs_a.delete();
      last_a = 8'hA5;
   endtask

   task automatic test_parity_err;
      ev_t got;
      send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_a.size() !== 1) begin
         errors++;
         $display("FAIL parity_count: got %0d events want 1", obs_a.size());
      end
      got = (obs_a.size() > 0) ? obs_a.pop_front() : 'x;
      checks++;
      if (got !== ev_t'({1'b0, 1'b1, 8'h3C})) begin
         errors++;
         $display("FAIL parity_event: got %h want %h", got, ev_t'({1'b0, 1'b1, 8'h3C}));
      end
      obs_a.delete();
      last_a = 8'h3C;
   endtask

   task automatic test_frame_err;
      ev_t got;
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
      repeat (20 * BAUD) @(negedge clk);
      checks++;
      if (obs_a.size() !== 1) begin
         errors++;
         $display("FAIL break_count: got %0d events want 1", obs_a.size());
      end
      got = (obs_a.size() > 0) ? obs_a.pop_front() : 'x;
      checks++;
      if (got !== ev_t'({1'b1, 1'b0, last_a})) begin
         errors++;
         $display("FAIL break_event: got %h want %h", got, ev_t'({1'b1, 1'b0, last_a}));
      end
      obs_a.delete();
      idle_bits(0, 2);
      send_frame(0, 8'h0F, 1'b0, 1'b1, 1'b1);
      got = (obs_a.size() == 1) ? obs_a.pop_front() : 'x;
      checks++;
      if (got !== ev_t'({1'b0, 1'b0, 8'h0F})) begin
         errors++;
         $display("FAIL after_break: got %h want %h", got, ev_t'({1'b0, 1'b0, 8'h0F}));
      end
      obs_a.delete();
      last_a = 8'h0F;
   endtask

   task automatic test_glitch;
      ev_t got;
      rx_a = 1'b0;
      repeat (2) @(negedge clk);
      rx_a = 1'b1;
      repeat (2 * BAUD) @(negedge clk);
      checks++;
      if ({obs_a.size() == 0, busy_a} !== 2'b10) begin
         errors++;
         $display("FAIL glitch: got events=%0d busy=%b want 0 and 0", obs_a.size(), busy_a);
      end
      obs_a.delete();
      send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1);
      got = (obs_a.size() == 1) ? obs_a.pop_front() : 'x;
      checks++;
      if (got !== ev_t'({1'b0, 1'b0, 8'h81})) begin
         errors++;
         $display("FAIL glitch_then_frame: got %h want %h", got, ev_t'({1'b0, 1'b0, 8'h81}));
      end
      obs_a.delete();
      last_a = 8'h81;
   endtask

   task automatic test_reset_midframe(input int use_sys);
      ev_t got;
      send_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
      checks++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("FAIL midframe_busy[%0d]: got %b want 1", use_sys, busy_a);
      end
      if (use_sys != 0) sys_reset = 1'b1; else reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({data_a, val_a, pe_a, fe_a, busy_a} !== 12'h000) begin
         errors++;
         $display("FAIL midframe_reset[%0d]: got %h want 000", use_sys,
                  {data_a, val_a, pe_a, fe_a, busy_a});
      end
      rx_a = 1'b1;
      @(negedge clk);
      sys_reset = 1'b0;
      reset     = 1'b1;
      last_a    = 8'h00;
      idle_bits(0, 2);
      checks++;
      if (obs_a.size() !== 0) begin
         errors++;
         $display("FAIL aborted_strobe[%0d]: got %0d events want 0", use_sys, obs_a.size());
      end
      obs_a.delete();
      obs_b.delete();
      send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1);
      got = (obs_a.size() == 1) ? obs_a.pop_front() : 'x;
      checks++;
      if (got !== ev_t'({1'b0, 1'b0, 8'h12})) begin
         errors++;
         $display("FAIL after_reset[%0d]: got %h want %h", use_sys, got,
                  ev_t'({1'b0, 1'b0, 8'h12}));
      end
      obs_a.delete();
      last_a = 8'h12;
   endtask

   task automatic test_enable_b;
      int  bhigh;
      ev_t got;
      bhigh = 0;
      en_b  = 1'b0;
      fork
         send_frame(1, 8'h77, 1'b0, 1'b1, 1'b0);
         for (int k = 0; k < 80; k++) begin
            if (busy_b) bhigh++;
            @(negedge clk);
         end
      join
      checks++;
      if (bhigh !== 0 || obs_b.size() !== 0) begin
         errors++;
         $display("FAIL disabled: got busy=%0d events=%0d want 0 0", bhigh, obs_b.size());
      end
      obs_b.delete();
      en_b = 1'b1;
      idle_bits(1, 1);
      send_frame(1, 8'h77, 1'b0, 1'b1, 1'b0);
      send_frame(1, 8'h88, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_b.size() !== 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d events want 2", obs_b.size());
      end
      got = (obs_b.size() > 0) ? obs_b.pop_front() : 'x;
      checks++;
      if (got !== ev_t'({1'b0, 1'b0, 8'h77})) begin
         errors++;
         $display("FAIL b2b_first: got %h want %h", got, ev_t'({1'b0, 1'b0, 8'h77}));
      end
      got = (obs_b.size() > 0) ? obs_b.pop_front() : 'x;
      checks++;
      if (got !== ev_t'({1'b0, 1'b0, 8'h88})) begin
         errors++;
         $display("FAIL b2b_second: got %h want %h", got, ev_t'({1'b0, 1'b0, 8'h88}));
      end
      obs_b.delete();
   endtask

   task automatic test_enable_midframe;
      ev_t got;
      fork
         send_frame(0, 8'h6B, 1'b1, 1'b1, 1'b1);
         begin
            repeat (30) @(negedge clk);
            en_a = 1'b0;
         end
      join
      got = (obs_a.size() == 1) ? obs_a.pop_front() : 'x;
      checks++;
      if (got !== ev_t'({1'b0, 1'b0, 8'h6B})) begin
         errors++;
         $display("FAIL enable_drop: got %h want %h", got, ev_t'({1'b0, 1'b0, 8'h6B}));
      end
      obs_a.delete();
      idle_bits(0, 1);
      send_frame(0, 8'h6B, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_a.size() !== 0) begin
         errors++;
         $display("FAIL enable_off_a: got %0d events want 0", obs_a.size());
      end
      obs_a.delete();
      en_a = 1'b1;
      idle_bits(0, 1);
      last_a = 8'h6B;
   endtask

   task automatic test_random;
      ev_t        exp_q[$];
      ev_t        got;
      logic [7:0] d;
      logic       p, s;
      int         gap;
      for (int n = 0; n < 24; n++) begin
         d = 8'($urandom);
         p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
         s = ($urandom_range(0, 4) != 0);
         send_frame(0, d, p, s, 1'b1);
         if (s) begin
            exp_q.push_back(ev_t'({1'b0, (^d) ^ p, d}));
            last_a = d;
            gap    = $urandom_range(0, 2);
         end else begin
            exp_q.push_back(ev_t'({1'b1, 1'b0, last_a}));
            repeat ($urandom_range(0, 2 * BAUD)) @(negedge clk);
            gap = 1 + $urandom_range(0, 1);
         end
         idle_bits(0, gap);
      end
      idle_bits(0, 1);
      checks++;
      if (obs_a.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d events want %0d", obs_a.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         got = (obs_a.size() > 0) ? obs_a.pop_front() : 'x;
         checks++;
         if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL rand_event: got %h want %h", got, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      obs_a.delete();
   endtask

   task automatic test_strobes;
      checks++;
      if (viol_a !== 0 || viol_b !== 0) begin
         errors++;
         $display("FAIL strobe_rules: got violations a=%0d b=%0d want 0 0", viol_a, viol_b);
      end
   endtask

   initial begin
      reset     = 1'b0;
      sys_reset = 1'b0;
      en_a      = 1'b1;
      en_b      = 1'b1;
      rx_a      = 1'b1;
      rx_b      = 1'b1;
      test_reset;
      test_basic;
      test_parity_err;
      test_frame_err;
      test_glitch;
      test_reset_midframe(0);
      test_reset_midframe(1);
      test_enable_b;
      test_enable_midframe;
      test_random;
      test_strobes;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
